// File: rtl/pin_sequencer_pkg.sv
// Shared FSM encoding and parameter defaults for the pin sequencer.
package pin_sequencer_pkg;

  localparam int NCH_DEF       = 3;
  localparam int PAT_LEN_DEF   = 8;
  localparam int DIV_W_DEF     = 24;
  localparam int STEP_W_DEF    = 25;
  localparam int MAX_STEPS_DEF = 20971520;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pin_sequencer_chan.sv
// One output channel: pattern/divider storage, step prescaler, pattern index and registered pin.
module pin_sequencer_chan
  import pin_sequencer_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               launch,
  input  logic               advance,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic               pin
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic [PAT_LEN-1:0] pattern;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;

  // PAT_LEN is a power of two, so the natural index overflow is the wrap.
  assign idx_next = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      div     <= '0;
      presc   <= '0;
      idx     <= '0;
      pin     <= 1'b0;
    end else begin
      if (load) begin
        pattern <= cfg_pattern;
        div     <= cfg_div;
      end
      // A write coincident with launch must shape the very first emitted bit.
      if (launch) begin
        presc <= '0;
        idx   <= '0;
        pin   <= load ? cfg_pattern[0] : pattern[0];
      end else if (advance) begin
        if (presc == div) begin
          presc <= '0;
          idx   <= idx_next;
          pin   <= pattern[idx_next];
        end else begin
          presc <= presc + DIV_W'(1);
        end
      end else begin
        pin <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pin_sequencer.sv
// Multi-channel pattern sequencer: runs a fixed number of cycles, each channel stepping its own pattern.
module pin_sequencer
  import pin_sequencer_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int PAT_LEN   = PAT_LEN_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int STEP_W    = STEP_W_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_ch,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic [NCH-1:0]     pins,
  output logic               busy,
  output logic               done,
  output logic [STEP_W-1:0]  step_count
);

  localparam logic [4:0]        NCH_LIM   = 5'(NCH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
  localparam logic [STEP_W-1:0] END_STEP  = STEP_W'(MAX_STEPS);

  state_e            state;
  state_e            state_next;
  logic [STEP_W-1:0] step_next;
  logic              last;
  logic              launch;
  logic              advance;
  logic              cfg_ok;

  assign last    = (step_count == LAST_STEP);
  assign launch  = start && !stop && (state != ST_RUN);
  assign advance = (state == ST_RUN) && !stop && !last;
  assign cfg_ok  = cfg_we && (state != ST_RUN) && ({1'b0, cfg_ch} < NCH_LIM);

  always_comb begin
    state_next = state;
    step_next  = step_count;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = ST_RUN;
            step_next  = '0;
          end
        end
        ST_RUN: begin
          if (last) begin
            state_next = ST_DONE;
            step_next  = END_STEP;
          end else begin
            step_next = step_count + STEP_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // busy/done come from the next state so they line up exactly with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      step_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      step_count <= step_next;
      busy       <= (state_next == ST_RUN);
      done       <= (state_next == ST_DONE);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    pin_sequencer_chan #(
      .PAT_LEN (PAT_LEN),
      .DIV_W   (DIV_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (cfg_ok && (cfg_ch == 4'(c))),
      .launch      (launch),
      .advance     (advance),
      .cfg_pattern (cfg_pattern),
      .cfg_div     (cfg_div),
      .pin         (pins[c])
    );
  end

endmodule

// File: tb/tb_pin_sequencer.sv
// Scoreboard bench for pin_sequencer with NCH=3, PAT_LEN=8, DIV_W=8, STEP_W=8, MAX_STEPS=20.
module tb_pin_sequencer;

  typedef struct packed {
    logic [2:0] pins;
    logic       busy;
    logic       done;
    logic [7:0] step;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       cfg_we;
  logic [3:0] cfg_ch;
  logic [7:0] cfg_pattern;
  logic [7:0] cfg_div;
  logic [2:0] pins;
  logic       busy;
  logic       done;
  logic [7:0] step_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  logic [7:0] p0 = 8'hA5;
  logic [7:0] p1 = 8'h0F;
  logic [7:0] p2 = 8'h3C;
  logic [7:0] p2n = 8'h01;
  logic       lit0 [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  pin_sequencer #(
    .NCH       (3),
    .PAT_LEN   (8),
    .DIV_W     (8),
    .STEP_W    (8),
    .MAX_STEPS (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_pattern (cfg_pattern),
    .cfg_div     (cfg_div),
    .pins        (pins),
    .busy        (busy),
    .done        (done),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [7:0] pat, input logic [7:0] dv);
    cfg_we = 1'b1; cfg_ch = ch; cfg_pattern = pat; cfg_div = dv;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    exp_t o;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_ch = 4'd0; cfg_pattern = 8'd0; cfg_div = 8'd0;
    #12;
    o = {pins, busy, done, step_count};
    n_tests++;
    if (o !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL reset got pins=%b busy=%b done=%b step=%0d want all zero", pins, busy, done, step_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_pattern_run;
    exp_t e, o;
    cfg_write(4'd0, p0, 8'd0);
    cfg_write(4'd1, p1, 8'd2);
    cfg_write(4'd2, p2, 8'd1);
    for (int i = 0; i < 20; i++) begin
      q.push_back(exp_t'{pins: {p2[(i/2)%8], p1[(i/3)%8], p0[i%8]}, busy: 1'b1, done: 1'b0, step: 8'(i)});
      if (i == 0) start = 1'b1;
      tick;
      start = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL run[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
      if (i < 9) begin
        n_tests++;
        if (pins[0] !== lit0[i]) begin
          n_fail++;
          $display("FAIL ch0_seq[%0d] got %b want %b", i, pins[0], lit0[i]);
        end
      end
      n_tests++;
      if (pins[1] !== (i < 12)) begin
        n_fail++;
        $display("FAIL ch1_hold[%0d] got %b want %b", i, pins[1], (i < 12));
      end
    end
    q.push_back(exp_t'{pins: 3'b000, busy: 1'b0, done: 1'b1, step: 8'd20});
    tick;
    e = q.pop_front();
    o = {pins, busy, done, step_count};
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL done_state got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
               o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
    end
  endtask

  task automatic test_restart;
    exp_t e, o;
    q.push_back(exp_t'{pins: 3'b011, busy: 1'b1, done: 1'b0, step: 8'd0});
    q.push_back(exp_t'{pins: 3'b010, busy: 1'b1, done: 1'b0, step: 8'd1});
    q.push_back(exp_t'{pins: 3'b000, busy: 1'b0, done: 1'b0, step: 8'd1});
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      stop  = (i == 2);
      tick;
      start = 1'b0; stop = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL restart[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
    end
  endtask

  task automatic test_stop;
    exp_t e, o;
    q.push_back(exp_t'{pins: 3'b000, busy: 1'b0, done: 1'b0, step: 8'd1});
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    e = q.pop_front();
    o = {pins, busy, done, step_count};
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL start_stop_idle got pins=%b busy=%b step=%0d want pins=%b busy=%b step=%0d",
               o.pins, o.busy, o.step, e.pins, e.busy, e.step);
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q.push_back(exp_t'{pins: {p2[(i/2)%8], p1[(i/3)%8], p0[i%8]}, busy: 1'b1, done: 1'b0, step: 8'(i)});
      else       q.push_back(exp_t'{pins: 3'b000, busy: 1'b0, done: 1'b0, step: 8'd7});
      start = (i == 0);
      stop  = (i == 8);
      tick;
      start = 1'b0; stop = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stop_run[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
    end
  endtask

  task automatic test_cfg_ignore;
    exp_t e, o;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) q.push_back(exp_t'{pins: {p2[(i/2)%8], p1[(i/3)%8], p0[i%8]}, busy: 1'b1, done: 1'b0, step: 8'(i)});
      else        q.push_back(exp_t'{pins: 3'b000, busy: 1'b0, done: 1'b0, step: 8'd9});
      start = (i == 0);
      stop  = (i == 10);
      cfg_we = (i == 3); cfg_ch = 4'd0; cfg_pattern = 8'h00; cfg_div = 8'd3;
      tick;
      start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cfg_in_run[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
    end
    cfg_write(4'd5, 8'h00, 8'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q.push_back(exp_t'{pins: {p2[(i/2)%8], p1[(i/3)%8], p0[i%8]}, busy: 1'b1, done: 1'b0, step: 8'(i)});
      else       q.push_back(exp_t'{pins: 3'b000, busy: 1'b0, done: 1'b0, step: 8'd7});
      start = (i == 0);
      stop  = (i == 8);
      tick;
      start = 1'b0; stop = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cfg_bad_ch[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      q.push_back(exp_t'{pins: {p2n[i%8], p1[(i/3)%8], p0[i%8]}, busy: 1'b1, done: 1'b0, step: 8'(i)});
      start = (i == 0);
      cfg_we = (i == 0); cfg_ch = 4'd2; cfg_pattern = p2n; cfg_div = 8'd0;
      tick;
      start = 1'b0; cfg_we = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cfg_with_start[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e, o;
    #2;
    rst_n = 1'b0;
    #1;
    o = {pins, busy, done, step_count};
    n_tests++;
    if (o !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset got pins=%b busy=%b done=%b step=%0d want all zero", pins, busy, done, step_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.push_back(exp_t'{pins: 3'b000, busy: 1'b1, done: 1'b0, step: 8'(i)});
      start = (i == 0);
      tick;
      start = 1'b0;
      e = q.pop_front();
      o = {pins, busy, done, step_count};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL post_reset_run[%0d] got pins=%b busy=%b done=%b step=%0d want pins=%b busy=%b done=%b step=%0d",
                 i, o.pins, o.busy, o.done, o.step, e.pins, e.busy, e.done, e.step);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish got time=%0t want < 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_pattern_run;
    test_restart;
    test_stop;
    test_cfg_ignore;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_sequencer.md
PIN_SEQUENCER -- requirements
Module: pin_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 3, number of output pin channels (1..16).
REQ-002 SHALL have parameter PAT_LEN, default 8, bits per channel pattern (power of two, 2..32).
REQ-003 SHALL have parameter DIV_W, default 24, width of per-channel step divider.
REQ-004 SHALL have parameter STEP_W, default 25, width of global run-length counter.
REQ-005 SHALL have parameter MAX_STEPS, default 20971520, clock cycles per run (1..2^STEP_W-1).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  begin run (one-cycle pulse or level).
REQ-009 SHALL have port stop  input  1  abort run.
REQ-010 SHALL have port cfg_we  input  1  config write strobe.
REQ-011 SHALL have port cfg_ch  input  4  target channel of config write.
REQ-012 SHALL have port cfg_pattern  input  PAT_LEN  pattern bits, bit 0 emitted first.
REQ-013 SHALL have port cfg_div  input  DIV_W  divider; pattern step lasts cfg_div+1 cycles.
REQ-014 SHALL have port pins  output  NCH  registered channel outputs.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  high in DONE.
REQ-017 SHALL have port step_count  output  STEP_W  cycles elapsed in current/last run.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DONE; busy=(RUN), done=(DONE), both registered.
REQ-019 IDLE/DONE + start=1, stop=0 at edge t SHALL enter RUN at t; step_count=0, every channel index=0, prescaler=0, pins[c]=pattern_c[0] after edge t.
REQ-020 In RUN, each edge SHALL increment step_count; when step_count==MAX_STEPS-1 the edge SHALL enter DONE, step_count=MAX_STEPS, pins=0.
REQ-021 Per channel in RUN: prescaler==div_c -> prescaler=0, index=(index+1) mod PAT_LEN (wraps to 0), pins[c]=pattern_c[new index]; else prescaler+1, pins[c] held.
REQ-022 div_c=0 SHALL advance index every cycle; all channels independent.
REQ-023 stop=1 in any state SHALL enter IDLE next edge, pins=0, step_count held; stop wins over simultaneous start.
REQ-024 start in RUN SHALL be ignored; start in DONE SHALL restart per REQ-019.
REQ-025 cfg_we=1 in IDLE or DONE with cfg_ch<NCH SHALL load pattern_c and div_c at that edge; cfg_ch>=NCH or state RUN SHALL ignore the write.
REQ-026 cfg_we coincident with start SHALL load config and start; the run SHALL use the new values from its first cycle.
REQ-027 pins SHALL be 0 in IDLE and DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, pins=0, busy=0, done=0, step_count=0, all patterns=0, all dividers=0, indices/prescalers=0, including mid-run.
REQ-029 First edge after rst_n deasserts SHALL be a normal edge (start honoured).

Structure
REQ-030 Package pin_sequencer_pkg SHALL hold the state enum and parameter defaults.
REQ-031 Per-channel prescaler, index and pattern register SHALL be sub-module pin_sequencer_chan, instantiated NCH times by generate.
REQ-032 No other sub-modules; no clock gating, no derived clocks.

Verification (NCH=3, PAT_LEN=8, DIV_W=8, STEP_W=8, MAX_STEPS=20)
REQ-033 Reset, write ch0 pattern 0xA5 div 0, start -> pins[0] over cycles 1..9 = 1,0,1,0,0,1,0,1,1 (wrap).
REQ-034 ch1 pattern 0x0F div 2 -> pins[1] each bit held 3 cycles: 1 x12 cycles, then 0 until DONE.
REQ-035 Run 20 cycles -> done=1, busy=0, step_count=20, pins=0; start again -> step_count restarts at 0.
REQ-036 start+stop same edge in IDLE -> stays IDLE; stop at cycle 7 of run -> IDLE, step_count=7, pins=0.
REQ-037 cfg_we during RUN to ch0 -> output unchanged; cfg_ch=5 write in IDLE -> no channel changes.
REQ-038 rst_n low at cycle 10 of run -> pins=0, busy=0 asynchronously, patterns cleared (restart yields pins=0).
